// File: rtl/key_event_engine.sv
// Multi-key debounce engine: synchronises raw buttons, debounces both edges on a shared ms tick,
// and reports held level, long-press and auto-repeat as registered levels and one-cycle pulses.
module key_event_engine #(
    parameter int N_KEYS      = 5,
    parameter int CLK_PER_MS  = 50000,
    parameter int DEBOUNCE_MS = 30,
    parameter int LONG_MS     = 2000,
    parameter int REPEAT_MS   = 200,
    parameter int ACTIVE_LOW  = 1,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_long,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] long_pulse,
    output logic [N_KEYS-1:0] repeat_pulse,
    output logic              tick_ms
);

    // state   | meaning
    // IDLE    | key released and accepted as released
    // DB_DN   | press seen, waiting DEBOUNCE_MS stable ticks
    // PRESSED | press accepted, timing toward long press
    // LONG    | long press reached, generating repeats
    // DB_UP   | release seen, waiting DEBOUNCE_MS stable ticks
    typedef enum logic [2:0] {IDLE, DB_DN, PRESSED, LONG, DB_UP} state_t;

    localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [PW-1:0]     P_LAST    = PW'(CLK_PER_MS - 1);
    localparam logic [CNT_W-1:0]  DB_LAST   = CNT_W'(DEBOUNCE_MS - 1);
    localparam logic [CNT_W-1:0]  LONG_LAST = CNT_W'(LONG_MS - 1);
    localparam logic [CNT_W-1:0]  REP_LAST  = CNT_W'((REPEAT_MS > 0) ? REPEAT_MS - 1 : 0);
    localparam logic [N_KEYS-1:0] RELEASED  = (ACTIVE_LOW != 0) ? {N_KEYS{1'b1}} : {N_KEYS{1'b0}};

    logic [PW-1:0]     pcnt;
    logic              tick;
    logic [N_KEYS-1:0] sync1, sync2, p;

    state_t            state_q [N_KEYS];
    state_t            state_d [N_KEYS];
    logic [CNT_W-1:0]  dcnt_q [N_KEYS];
    logic [CNT_W-1:0]  dcnt_d [N_KEYS];
    logic [CNT_W-1:0]  hcnt_q [N_KEYS];
    logic [CNT_W-1:0]  hcnt_d [N_KEYS];
    logic [CNT_W-1:0]  rcnt_q [N_KEYS];
    logic [CNT_W-1:0]  rcnt_d [N_KEYS];
    logic [N_KEYS-1:0] level_d, long_d, press_d, release_d, lp_d, rp_d;

    assign tick    = (pcnt == P_LAST);
    assign tick_ms = tick;
    assign p       = (ACTIVE_LOW != 0) ? ~sync2 : sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt  <= '0;
            sync1 <= RELEASED;
            sync2 <= RELEASED;
        end else begin
            pcnt  <= tick ? '0 : pcnt + 1'b1;
            sync1 <= key;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_KEYS; i++) begin
                state_q[i] <= IDLE;
                dcnt_q[i]  <= '0;
                hcnt_q[i]  <= '0;
                rcnt_q[i]  <= '0;
            end
            key_level     <= '0;
            key_long      <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
            long_pulse    <= '0;
            repeat_pulse  <= '0;
        end else begin
            for (int i = 0; i < N_KEYS; i++) begin
                state_q[i] <= state_d[i];
                dcnt_q[i]  <= dcnt_d[i];
                hcnt_q[i]  <= hcnt_d[i];
                rcnt_q[i]  <= rcnt_d[i];
            end
            key_level     <= level_d;
            key_long      <= long_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
            long_pulse    <= lp_d;
            repeat_pulse  <= rp_d;
        end
    end

    // A change of p always wins over a coincident tick: the state exits and the tick is dropped.
    always_comb begin
        level_d   = key_level;
        long_d    = key_long;
        press_d   = '0;
        release_d = '0;
        lp_d      = '0;
        rp_d      = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            state_d[i] = state_q[i];
            dcnt_d[i]  = dcnt_q[i];
            hcnt_d[i]  = hcnt_q[i];
            rcnt_d[i]  = rcnt_q[i];
            case (state_q[i])
                IDLE: begin
                    if (p[i]) begin
                        state_d[i] = DB_DN;
                        dcnt_d[i]  = '0;
                    end
                end
                DB_DN: begin
                    if (!p[i]) begin
                        state_d[i] = IDLE;
                    end else if (tick) begin
                        if (dcnt_q[i] == DB_LAST) begin
                            state_d[i] = PRESSED;
                            level_d[i] = 1'b1;
                            press_d[i] = 1'b1;
                            hcnt_d[i]  = '0;
                        end else begin
                            dcnt_d[i] = dcnt_q[i] + 1'b1;
                        end
                    end
                end
                PRESSED: begin
                    if (!p[i]) begin
                        state_d[i] = DB_UP;
                        dcnt_d[i]  = '0;
                    end else if (tick) begin
                        if (hcnt_q[i] == LONG_LAST) begin
                            state_d[i] = LONG;
                            long_d[i]  = 1'b1;
                            lp_d[i]    = 1'b1;
                            rcnt_d[i]  = '0;
                        end else begin
                            hcnt_d[i] = hcnt_q[i] + 1'b1;
                        end
                    end
                end
                LONG: begin
                    if (!p[i]) begin
                        state_d[i] = DB_UP;
                        dcnt_d[i]  = '0;
                    end else if (tick && (REPEAT_MS > 0)) begin
                        if (rcnt_q[i] == REP_LAST) begin
                            rp_d[i]   = 1'b1;
                            rcnt_d[i] = '0;
                        end else begin
                            rcnt_d[i] = rcnt_q[i] + 1'b1;
                        end
                    end
                end
                DB_UP: begin
                    // hcnt/rcnt deliberately untouched so a bounce resumes the hold timing.
                    if (p[i]) begin
                        state_d[i] = key_long[i] ? LONG : PRESSED;
                    end else if (tick) begin
                        if (dcnt_q[i] == DB_LAST) begin
                            state_d[i]   = IDLE;
                            level_d[i]   = 1'b0;
                            long_d[i]    = 1'b0;
                            release_d[i] = 1'b1;
                        end else begin
                            dcnt_d[i] = dcnt_q[i] + 1'b1;
                        end
                    end
                end
                default: state_d[i] = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_event_engine.sv
// Bench for key_event_engine: a run-length reference model scores every cycle, while per-scenario
// tasks check latencies, pulse counts and ordering directly.
module tb_key_event_engine;

    localparam int N   = 5;
    localparam int CPM = 4;
    localparam int DB  = 3;
    localparam int LG  = 10;
    localparam int RP  = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] key = '1;

    logic [N-1:0] lvl_a, lng_a, prs_a, rel_a, lp_a, rp_a;
    logic [N-1:0] lvl_b, lng_b, prs_b, rel_b, lp_b, rp_b;
    logic         tick_a, tick_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    key_event_engine #(.N_KEYS(N), .CLK_PER_MS(CPM), .DEBOUNCE_MS(DB), .LONG_MS(LG),
                       .REPEAT_MS(RP), .ACTIVE_LOW(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .key(key), .key_level(lvl_a), .key_long(lng_a),
        .press_pulse(prs_a), .release_pulse(rel_a), .long_pulse(lp_a),
        .repeat_pulse(rp_a), .tick_ms(tick_a));

    key_event_engine #(.N_KEYS(N), .CLK_PER_MS(CPM), .DEBOUNCE_MS(DB), .LONG_MS(LG),
                       .REPEAT_MS(0), .ACTIVE_LOW(1), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .key(key), .key_level(lvl_b), .key_long(lng_b),
        .press_pulse(prs_b), .release_pulse(rel_b), .long_pulse(lp_b),
        .repeat_pulse(rp_b), .tick_ms(tick_b));

    // Reference model: a tick counts toward a run only if p held its value since the previous cycle.
    int           m_pre;
    logic [N-1:0] m_s1, m_s2, m_level, m_long, m_press, m_rel, m_lp, m_rp;
    logic         m_tk, m_pc;
    logic         pprev [N];
    int           run [N];
    int           hold [N];
    int           rep [N];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pre = 0; m_s1 = '1; m_s2 = '1;
            m_level = '0; m_long = '0; m_press = '0; m_rel = '0; m_lp = '0; m_rp = '0;
            for (int k = 0; k < N; k++) begin
                pprev[k] = 1'b0; run[k] = 0; hold[k] = 0; rep[k] = 0;
            end
        end else begin
            m_tk  = (m_pre == CPM - 1);
            m_pre = m_tk ? 0 : m_pre + 1;
            m_press = '0; m_rel = '0; m_lp = '0; m_rp = '0;
            for (int k = 0; k < N; k++) begin
                m_pc = ~m_s2[k];
                if (m_pc != pprev[k]) begin
                    run[k] = 0;
                end else if (m_tk) begin
                    if (m_pc != m_level[k]) begin
                        run[k]++;
                        if (run[k] == DB) begin
                            run[k] = 0;
                            m_level[k] = m_pc;
                            if (m_pc) begin
                                m_press[k] = 1'b1; hold[k] = 0;
                            end else begin
                                m_rel[k] = 1'b1; m_long[k] = 1'b0;
                            end
                        end
                    end else if (m_pc) begin
                        if (!m_long[k]) begin
                            hold[k]++;
                            if (hold[k] == LG) begin
                                m_long[k] = 1'b1; m_lp[k] = 1'b1; rep[k] = 0;
                            end
                        end else begin
                            rep[k]++;
                            if (rep[k] == RP) begin
                                m_rp[k] = 1'b1; rep[k] = 0;
                            end
                        end
                    end
                end
                pprev[k] = m_pc;
            end
            m_s2 = m_s1;
            m_s1 = key;
        end
    end

    // Cycle scoreboard, sampled on the falling edge.
    int sb_prints = 0;
    always @(negedge clk) begin
        logic [6*N:0] exp_a, got_a, exp_b, got_b;
        exp_a = {m_level, m_long, m_press, m_rel, m_lp, m_rp, (m_pre == CPM - 1)};
        got_a = {lvl_a, lng_a, prs_a, rel_a, lp_a, rp_a, tick_a};
        exp_b = {m_level, m_long, m_press, m_rel, m_lp, {N{1'b0}}, (m_pre == CPM - 1)};
        got_b = {lvl_b, lng_b, prs_b, rel_b, lp_b, rp_b, tick_b};
        checks += 2;
        if (got_a !== exp_a) begin
            errors++;
            if (sb_prints < 20) $display("FAIL model_a t=%0t got %h expected %h", $time, got_a, exp_a);
            sb_prints++;
        end
        if (got_b !== exp_b) begin
            errors++;
            if (sb_prints < 20) $display("FAIL model_b t=%0t got %h expected %h", $time, got_b, exp_b);
            sb_prints++;
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        key = '1;
        repeat (3) @(negedge clk);
        checks++;
        if ({lvl_a, lng_a, prs_a, rel_a, lp_a, rp_a, tick_a} !== '0) begin
            errors++;
            $display("FAIL reset_a got %h expected 0", {lvl_a, lng_a, prs_a, rel_a, lp_a, rp_a, tick_a});
        end
        checks++;
        if ({lvl_b, lng_b, prs_b, rel_b, lp_b, rp_b, tick_b} !== '0) begin
            errors++;
            $display("FAIL reset_b got %h expected 0", {lvl_b, lng_b, prs_b, rel_b, lp_b, rp_b, tick_b});
        end
        rst = 1'b0;
    endtask

    task automatic test_clean_press();
        int t_press = -1;
        int t_long  = -1;
        int reps[$];
        @(negedge clk);
        key[0] = 1'b0;
        for (int n = 1; n <= 130; n++) begin
            @(posedge clk); #1;
            if (prs_a[0] && t_press < 0) t_press = n;
            if (lp_a[0] && t_long < 0) t_long = n;
            if (rp_a[0]) reps.push_back(n);
        end
        checks++;
        if (t_press < 11 || t_press > 15) begin
            errors++;
            $display("FAIL press_latency got %0d expected 11..15", t_press);
        end
        checks++;
        if (t_long - t_press != 40) begin
            errors++;
            $display("FAIL long_latency got %0d expected 40", t_long - t_press);
        end
        for (int r = 0; r < 3; r++) begin
            checks++;
            if (reps.size() <= r || reps[r] != t_long + 16 * (r + 1)) begin
                errors++;
                $display("FAIL repeat_%0d got %0d expected %0d", r,
                         (reps.size() > r) ? reps[r] - t_long : -1, 16 * (r + 1));
            end
        end
        checks++;
        if (lvl_a[0] !== 1'b1) begin
            errors++;
            $display("FAIL level_held got %b expected 1", lvl_a[0]);
        end
        @(negedge clk);
        key[0] = 1'b1;
        repeat (30) @(negedge clk);
        checks++;
        if (lvl_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL level_released got %b expected 0", lvl_a[0]);
        end
    endtask

    task automatic test_glitch();
        logic hits = 1'b0;
        for (int n = 0; n < 46; n++) begin
            @(negedge clk);
            if (n == 0) key[1] = 1'b0;
            if (n == 6) key[1] = 1'b1;
            @(posedge clk); #1;
            hits = hits | prs_a[1] | rel_a[1] | lp_a[1] | rp_a[1] | lvl_a[1] | lng_a[1];
        end
        checks++;
        if (hits !== 1'b0) begin
            errors++;
            $display("FAIL glitch_key1 got activity %b expected 0", hits);
        end
    endtask

    task automatic test_bouncy_release();
        int presses = 0;
        int releases = 0;
        int t_rel = -1;
        for (int n = 0; n < 110; n++) begin
            @(negedge clk);
            if (n < 60)      key[2] = 1'b0;
            else if (n < 62) key[2] = 1'b1;
            else if (n < 64) key[2] = 1'b0;
            else if (n < 66) key[2] = 1'b1;
            else if (n < 68) key[2] = 1'b0;
            else             key[2] = 1'b1;
            @(posedge clk); #1;
            if (prs_a[2]) presses++;
            if (rel_a[2]) begin
                releases++;
                if (t_rel < 0) t_rel = n - 68 + 1;
            end
        end
        checks++;
        if (presses != 1) begin
            errors++;
            $display("FAIL bouncy_presses got %0d expected 1", presses);
        end
        checks++;
        if (releases != 1) begin
            errors++;
            $display("FAIL bouncy_releases got %0d expected 1", releases);
        end
        checks++;
        if (t_rel < 11 || t_rel > 15) begin
            errors++;
            $display("FAIL bouncy_release_latency got %0d expected 11..15", t_rel);
        end
    endtask

    task automatic test_simultaneous();
        int t3 = -1;
        int t4 = -1;
        @(negedge clk);
        key[3] = 1'b0;
        key[4] = 1'b0;
        for (int n = 1; n <= 25; n++) begin
            @(posedge clk); #1;
            if (prs_a[3] && t3 < 0) t3 = n;
            if (prs_a[4] && t4 < 0) t4 = n;
        end
        checks++;
        if (t3 < 0 || t3 != t4) begin
            errors++;
            $display("FAIL simultaneous_press got %0d and %0d expected equal", t3, t4);
        end
        @(negedge clk);
        key[3] = 1'b1;
        key[4] = 1'b1;
        repeat (30) @(negedge clk);
    endtask

    task automatic test_repeat_disable();
        int longs_b = 0;
        int reps_b  = 0;
        int reps_a  = 0;
        @(negedge clk);
        key[3] = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); #1;
            if (lp_b[3]) longs_b++;
            if (rp_b[3]) reps_b++;
            if (rp_a[3]) reps_a++;
        end
        checks++;
        if (longs_b != 1) begin
            errors++;
            $display("FAIL norepeat_longs got %0d expected 1", longs_b);
        end
        checks++;
        if (reps_b != 0) begin
            errors++;
            $display("FAIL norepeat_repeats got %0d expected 0", reps_b);
        end
        checks++;
        if (reps_a < 8) begin
            errors++;
            $display("FAIL repeat_enabled_count got %0d expected at least 8", reps_a);
        end
        @(negedge clk);
        key[3] = 1'b1;
        repeat (30) @(negedge clk);
    endtask

    task automatic test_reset_mid_hold();
        int waited = 0;
        int t_press = -1;
        int rels = 0;
        @(negedge clk);
        key[0] = 1'b0;
        while (lng_a[0] !== 1'b1 && waited < 150) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (lng_a[0] !== 1'b1) begin
            errors++;
            $display("FAIL reach_long got %b expected 1 (timeout)", lng_a[0]);
        end
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({lvl_a, lng_a, prs_a, rel_a, lp_a, rp_a, lvl_b, lng_b, prs_b, rel_b, lp_b, rp_b} !== '0) begin
            errors++;
            $display("FAIL async_reset got %h %h expected 0",
                     {lvl_a, lng_a, prs_a, rel_a, lp_a, rp_a}, {lvl_b, lng_b, prs_b, rel_b, lp_b, rp_b});
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (rel_a[0]) rels++;
            if (prs_a[0] && t_press < 0) t_press = n;
        end
        checks++;
        if (rels != 0) begin
            errors++;
            $display("FAIL reset_no_release got %0d expected 0", rels);
        end
        checks++;
        if (t_press < 11 || t_press > 15) begin
            errors++;
            $display("FAIL repress_latency got %0d expected 11..15", t_press);
        end
        @(negedge clk);
        key[0] = 1'b1;
        repeat (30) @(negedge clk);
    endtask

    task automatic test_random();
        int seg [N];
        int npress [N];
        int nrel [N];
        int orphan_repeats = 0;
        logic [N-1:0] long_seen = '0;
        for (int k = 0; k < N; k++) begin
            seg[k] = $urandom_range(0, 40); npress[k] = 0; nrel[k] = 0;
        end
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                if (seg[k] == 0) begin
                    key[k] = ~key[k];
                    seg[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : $urandom_range(10, 120);
                end else begin
                    seg[k]--;
                end
            end
            @(posedge clk); #1;
            for (int k = 0; k < N; k++) begin
                if (prs_a[k]) begin npress[k]++; long_seen[k] = 1'b0; end
                if (lp_a[k]) long_seen[k] = 1'b1;
                if (rp_a[k] && !long_seen[k]) orphan_repeats++;
                if (rel_a[k]) nrel[k]++;
            end
        end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (npress[k] - nrel[k] != int'(lvl_a[k])) begin
                errors++;
                $display("FAIL random_balance_key%0d got %0d expected %0d", k, npress[k] - nrel[k], lvl_a[k]);
            end
        end
        checks++;
        if (orphan_repeats != 0) begin
            errors++;
            $display("FAIL random_repeat_before_long got %0d expected 0", orphan_repeats);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_bouncy_release();
        test_simultaneous();
        test_repeat_disable();
        test_reset_mid_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
